// File: rtl/avalon_pio_ext_if.sv
// Avalon-MM slave bus bundle for the GPIO register block (s1).
interface avalon_pio_ext_if;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 32;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/avalon_pio_ext.sv
// Parametrised Avalon-MM GPIO: per-bit direction, atomic set/clear,
// synchronised inputs with edge capture and a masked level interrupt.
module avalon_pio_ext #(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '0,
    parameter int unsigned      EDGE_TYPE   = 0,
    parameter int unsigned      SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    avalon_pio_ext_if.slave     s1,
    input  logic [WIDTH-1:0]    in_port,
    output logic [WIDTH-1:0]    out_port,
    output logic [WIDTH-1:0]    oe,
    output logic                irq
);
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned CNT_W     = 3;
    localparam int unsigned ARM_COUNT = SYNC_STAGES + 1;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    logic [WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_edgecap;
    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;
    logic             r_irq;
    logic [CNT_W-1:0] r_arm_cnt;

    logic             w_wr;
    logic [WIDTH-1:0] w_wd;
    logic [WIDTH-1:0] w_in_sync;
    logic             w_armed;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_sel_raw;
    logic [WIDTH-1:0] w_sel;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_readdata;

    assign w_wr      = s1.chipselect & ~s1.write_n;
    assign w_wd      = s1.writedata[WIDTH-1:0];
    assign w_in_sync = r_sync[SYNC_STAGES-1];
    assign w_armed   = (r_arm_cnt == CNT_W'(ARM_COUNT));
    assign w_rise    = w_in_sync & ~r_prev;
    assign w_fall    = ~w_in_sync & r_prev;
    assign w_clr     = (w_wr && (s1.address == ADDR_EDGECAP)) ? w_wd : '0;

    // Select which edge polarity is reported
    always_comb begin
        w_sel_raw = w_rise;
        if (EDGE_TYPE == 1)
            w_sel_raw = w_fall;
        else if (EDGE_TYPE == 2)
            w_sel_raw = w_rise | w_fall;
    end

    // Only input bits report edges, and only once the sync chain has settled
    assign w_sel = w_armed ? (w_sel_raw & ~r_dir) : '0;

    // Software-visible control registers written from the bus
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out <= RESET_VALUE;
            r_dir      <= DIR_RESET;
            r_mask     <= '0;
        end else if (w_wr) begin
            case (s1.address)
                ADDR_DATA:    r_data_out <= w_wd;
                ADDR_DIR:     r_dir      <= w_wd;
                ADDR_IRQMASK: r_mask     <= w_wd;
                ADDR_OUTSET:  r_data_out <= r_data_out | w_wd;
                ADDR_OUTCLR:  r_data_out <= r_data_out & ~w_wd;
                default:      ;
            endcase
        end
    end

    // Input synchroniser chain and previous-sample register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                r_sync[i] <= '0;
            r_prev <= '0;
        end else begin
            r_sync[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++)
                r_sync[i] <= r_sync[i-1];
            r_prev <= w_in_sync;
        end
    end

    // Arming counter: suppress edges until reset-time pin levels are flushed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_arm_cnt <= '0;
        else if (!w_armed)
            r_arm_cnt <= r_arm_cnt + CNT_W'(1);
    end

    // Edge capture; a new edge wins over a simultaneous write-1-to-clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_edgecap <= '0;
        else
            r_edgecap <= (r_edgecap & ~w_clr) | w_sel;
    end

    // Registered level interrupt from unmasked captured edges
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_irq <= 1'b0;
        else
            r_irq <= |(r_edgecap & r_mask);
    end

    // Combinational read mux; output bits read back data_out, inputs read the pad
    always_comb begin
        w_readdata = '0;
        case (s1.address)
            ADDR_DATA:    w_readdata = (r_dir & r_data_out) | (~r_dir & w_in_sync);
            ADDR_DIR:     w_readdata = r_dir;
            ADDR_IRQMASK: w_readdata = r_mask;
            ADDR_EDGECAP: w_readdata = r_edgecap;
            default:      w_readdata = '0;
        endcase
    end

    assign s1.readdata = DATA_W'(w_readdata);
    assign out_port    = r_data_out;
    assign oe          = r_dir;
    assign irq         = r_irq;
endmodule

// File: tb/tb_avalon_pio_ext.sv
// Self-checking bench for avalon_pio_ext: directed scenarios plus random
// bus/pin traffic compared against a behavioural model.
module tb_avalon_pio_ext;
    localparam int unsigned W    = 8;
    localparam int unsigned S    = 3;
    localparam int unsigned EDGE = 0;
    localparam logic [W-1:0] RV  = 8'h00;
    localparam logic [W-1:0] DR  = 8'h00;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] in_port;
    logic [W-1:0] out_port;
    logic [W-1:0] oe;
    logic         irq;

    avalon_pio_ext_if bus ();

    avalon_pio_ext #(
        .WIDTH(W), .RESET_VALUE(RV), .DIR_RESET(DR),
        .EDGE_TYPE(EDGE), .SYNC_STAGES(S)
    ) dut (
        .clk(clk), .reset_n(reset_n), .s1(bus.slave),
        .in_port(in_port), .out_port(out_port), .oe(oe), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Behavioural model state
    logic [W-1:0] m_dout, m_dir, m_mask, m_ecap;
    logic         m_irq;
    logic [W-1:0] m_hist [$];   // pin samples, newest first
    int           m_edges;      // clock edges since reset release

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_dout  = RV;
        m_dir   = DR;
        m_mask  = '0;
        m_ecap  = '0;
        m_irq   = 1'b0;
        m_hist  = {};
        for (int i = 0; i <= int'(S); i++) m_hist.push_back('0);
        m_edges = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        logic [W-1:0] v;
        case (a)
            3'd0:    v = (m_dir & m_dout) | (~m_dir & m_hist[S-1]);
            3'd1:    v = m_dir;
            3'd2:    v = m_mask;
            3'd3:    v = m_ecap;
            default: v = '0;
        endcase
        return 32'(v);
    endfunction

    // One clock: check readdata before the edge, advance model, check outputs after
    task automatic step();
        logic [W-1:0] insync, prev, sel, clr, wd, n_dout, n_dir, n_mask, n_ecap, pin;
        logic         wr, n_irq;
        @(negedge clk);
        check("readdata", bus.readdata, model_read(bus.address));
        insync = m_hist[S-1];
        prev   = m_hist[S];
        case (EDGE)
            0:       sel = insync & ~prev;
            1:       sel = ~insync & prev;
            default: sel = insync ^ prev;
        endcase
        if (m_edges < int'(S) + 1) sel = '0;
        sel    = sel & ~m_dir;
        wr     = bus.chipselect && !bus.write_n;
        wd     = bus.writedata[W-1:0];
        n_dout = m_dout;
        n_dir  = m_dir;
        n_mask = m_mask;
        clr    = '0;
        if (wr) begin
            case (bus.address)
                3'd0: n_dout = wd;
                3'd1: n_dir  = wd;
                3'd2: n_mask = wd;
                3'd3: clr    = wd;
                3'd4: n_dout = m_dout | wd;
                3'd5: n_dout = m_dout & ~wd;
                default: ;
            endcase
        end
        n_ecap = (m_ecap & ~clr) | sel;
        n_irq  = |(m_ecap & m_mask);
        pin    = in_port;
        @(posedge clk);
        #1;
        m_dout = n_dout; m_dir = n_dir; m_mask = n_mask; m_ecap = n_ecap; m_irq = n_irq;
        m_hist.push_front(pin);
        void'(m_hist.pop_back());
        m_edges++;
        check("out_port", 32'(out_port), 32'(m_dout));
        check("oe", 32'(oe), 32'(m_dir));
        check("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
        step();
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
        step();
        bus.chipselect = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic peek(input string tag, input logic [2:0] a, input logic [31:0] exp);
        bus.address = a;
        #1;
        check(tag, bus.readdata, exp);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset_n = 1'b0;
        in_port = '1;
        bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_port", 32'(out_port), 32'(RV));
        check("rst_oe", 32'(oe), 32'(DR));
        check("rst_irq", 32'(irq), 32'd0);
        reset_n = 1'b1;

        // Pins high through reset must not produce an edge
        wr(3'd2, 32'hFF);
        idle(8);
        peek("t1_edgecap", 3'd3, 32'h0);
        check("t1_irq", 32'(irq), 32'd0);

        // Data, set and clear
        wr(3'd1, 32'hFF);
        wr(3'd0, 32'hA5);
        check("t2_data", 32'(out_port), 32'hA5);
        wr(3'd4, 32'h0F);
        check("t2_outset", 32'(out_port), 32'hAF);
        wr(3'd5, 32'h81);
        check("t2_outclr", 32'(out_port), 32'h2E);
        check("t2_oe", 32'(oe), 32'hFF);
        wr(3'd1, 32'h00);

        // Rising edge latency to EDGECAP and irq, then W1C
        in_port = '0;
        idle(S + 3);
        wr(3'd3, 32'hFF);
        wr(3'd2, 32'h01);
        in_port = 8'h01;
        bus.address = 3'd3;
        for (int k = 0; k <= int'(S) + 1; k++) begin
            step();
            check("t3_edgecap", bus.readdata, (k >= int'(S)) ? 32'h1 : 32'h0);
            check("t3_irq", 32'(irq), (k >= int'(S) + 1) ? 32'd1 : 32'd0);
        end
        wr(3'd3, 32'h01);
        check("t3_irq_hold", 32'(irq), 32'd1);
        step();
        check("t3_irq_drop", 32'(irq), 32'd0);

        // New edge beats a simultaneous clear of the same bit
        in_port = '0;
        idle(S + 3);
        wr(3'd3, 32'hFF);
        in_port = 8'h01;
        idle(S);
        wr(3'd3, 32'h01);
        peek("t4_edgecap", 3'd3, 32'h1);

        // Direction change with output high and pad low gives no edge
        in_port = '0;
        wr(3'd1, 32'h08);
        wr(3'd0, 32'h08);
        idle(S + 3);
        wr(3'd3, 32'hFF);
        wr(3'd1, 32'h00);
        idle(S + 3);
        peek("t5_edgecap", 3'd3, 32'h0);
        peek("t5_data", 3'd0, 32'h0);

        // Upper bits and unused addresses
        wr(3'd1, 32'hFFFF_FFFF);
        wr(3'd0, 32'hFFFF_FF5A);
        peek("t6_data_upper", 3'd0, 32'h5A);
        peek("t6_addr6", 3'd6, 32'h0);
        wr(3'd7, 32'hFFFF_FFFF);
        check("t6_addr7_out", 32'(out_port), 32'h5A);
        check("t6_addr7_oe", 32'(oe), 32'hFF);
        rd(3'd1); rd(3'd2); rd(3'd3); rd(3'd6); rd(3'd7);

        // Random traffic with an asynchronous reset in the middle
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                @(negedge clk);
                #2;
                reset_n = 1'b0;
                #1;
                check("async_out_port", 32'(out_port), 32'(RV));
                check("async_oe", 32'(oe), 32'(DR));
                check("async_irq", 32'(irq), 32'd0);
                peek("async_edgecap", 3'd3, 32'h0);
                model_reset();
                bus.chipselect = 1'b0; bus.write_n = 1'b1;
                @(posedge clk);
                #1;
                reset_n = 1'b1;
            end
            bus.address    = 3'($urandom_range(0, 7));
            bus.chipselect = 1'($urandom_range(0, 1));
            bus.write_n    = ($urandom_range(0, 3) != 0);
            bus.writedata  = $urandom;
            if ($urandom_range(0, 3) == 0) in_port = W'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
